key_event_ctrl: RTL
===================

# key_event_ctrl

Event controller placed downstream of the 4-key debouncer. It turns the debounced, active-low key levels into a queue of timed key events: press, long-press, auto-repeat and release. Per-key state machines produce the events, a fixed-priority arbiter serialises them into a small FIFO, and a valid/ready port delivers them to the UI/CPU side.

## Interface
- TICK_DIV, 50_000: sys_clk cycles per 1 ms tick (50 MHz clock).
- LONG_MS, 1000: ms held before a LONG event is emitted.
- REPEAT_MS, 200: ms between REPEAT events after LONG.
- FIFO_DEPTH, 4: event FIFO entries (power of 2, ≥2).
- sys_clk  in  1  system clock, 50 MHz.
- sys_rstn  in  1  reset, asynchronous, active-low.
- key_level  in  4  debounced key levels; 0 = pressed. Already synchronous to sys_clk.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  consumer accepts the head; a pop happens when valid && ready.
- evt_key  out  2  key index of the head event.
- evt_type  out  2  00 RELEASE, 01 PRESS, 10 LONG, 11 REPEAT.
- evt_overflow  out  1  sticky flag: an event was dropped.
- clr_overflow  in  1  single-cycle pulse; clears evt_overflow.

## Operation
- Reset values:
  - evt_valid=0, evt_key=0, evt_type=0, evt_overflow=0.
  - FIFO empty, all FSMs IDLE, ms counters 0, tick counter 0.
  - Previous-level register = 4'b1111.
- Tick: a free-running counter runs 0..TICK_DIV-1 and wraps. tick=1 on the single cycle the count equals TICK_DIV-1.
- Per-key FSM states: IDLE, HELD, REPEAT. Each key has a 16-bit ms counter that saturates at all-ones.
  - IDLE: level 1→0 edge → raise PRESS pending, clear counter, go to HELD.
  - HELD: counter increments on each tick. When it reaches LONG_MS → raise LONG pending, clear counter, go to REPEAT.
  - REPEAT: counter increments on each tick. When it reaches REPEAT_MS → raise REPEAT pending, clear counter.
  - HELD or REPEAT: level 0→1 edge → raise RELEASE pending, go to IDLE. Release takes priority over a same-cycle LONG or REPEAT.
- Pending: each key has one pending slot (valid bit + type).
  - Arbiter: fixed priority, key 0 highest. It writes one pending event per cycle into the FIFO when the FIFO is not full, then clears that slot.
  - If a new event is raised while the key's slot is still occupied, the new event is dropped and evt_overflow is set. The slot keeps the older event.
- FIFO: show-ahead. evt_key and evt_type are the head entry; evt_valid = !empty, registered count.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap.
  - Count has one extra bit.
- If clr_overflow coincides with a new drop, the flag stays set (set wins).
- Reset mid-operation: FSMs, FIFO and flags clear immediately. A key held through reset gives a PRESS on the first cycle it is sampled low after reset, because the previous level resets to 1.

## Timing
- Key edge sampled at edge N → pending at N+1 → FIFO write at N+2 → evt_valid=1 after edge N+2. This holds if the FIFO was empty and no higher-priority slot was pending.
- Latency adds one cycle for each higher-priority key pending in the same cycle.
- Pop at edge M: the next head is visible after M. evt_valid drops after M if the FIFO is then empty.
- LONG fires LONG_MS ticks after PRESS (±1 tick of phase). REPEATs then fire every REPEAT_MS ticks.
- evt_key and evt_type are stable while evt_valid && !evt_ready.

## Configuration
- KEY_EVT_REPEAT_EN defined: the REPEAT state and REPEAT events exist as described above.
- Not defined: after LONG the FSM stays in HELD with the counter saturated and emits no further events until RELEASE. Encoding 11 never appears. The REPEAT_MS parameter is still declared but unused.

## Structure
- Package key_evt_pkg holds:
  - evt_type encodings EVT_RELEASE, EVT_PRESS, EVT_LONG, EVT_REPEAT.
  - FSM state encodings.
  - Event struct {key[1:0], type[1:0]}.
  - Default timing constants.
- One sub-module, key_evt_fifo: synchronous show-ahead FIFO with full/empty and simultaneous push/pop.
- Per-key FSMs and the arbiter are in the top level.

## Test plan
- TICK_DIV=4, LONG_MS=5, REPEAT_MS=2; press key 2 and hold 20 ticks, evt_ready=1 → PRESS(2), LONG(2) at 5 ticks, then REPEAT(2) every 2 ticks, then RELEASE(2) on release.
- Keys 0 and 3 fall in the same cycle → PRESS(0) written at N+2, PRESS(3) at N+3; evt_valid latency is 2 cycles.
- evt_ready=0, six distinct events from four keys → FIFO fills at 4 and slots hold the rest. A second event on an occupied key sets evt_overflow=1. clr_overflow clears it.
- FIFO full with a slot pending, one cycle of evt_ready=1 → pop and push in the same cycle, count stays 4, ordering is preserved.
- Assert sys_rstn low while key 1 is held in REPEAT, then release reset with the key still low → all outputs 0, then PRESS(1) at cycle 2 after reset.
- Build without KEY_EVT_REPEAT_EN, hold 3×LONG_MS → only PRESS, LONG, RELEASE appear.

Source files
------------

// File: rtl/key_evt_pkg.sv
// key_evt_pkg: shared encodings, event record and default timing constants
// for the key event controller.
package key_evt_pkg;

  // Event type as seen on the evt_type output
  typedef enum logic [1:0] {
    EVT_RELEASE = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_LONG    = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_t;

  // Per-key state machine states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HELD   = 2'b01,
    ST_REPEAT = 2'b10
  } key_state_t;

  // One queued event: which key and what happened
  typedef struct packed {
    logic [1:0] key;
    logic [1:0] etype;
  } key_evt_t;

  // Default timing: 50 MHz clock, 1 ms tick
  localparam int DEF_TICK_DIV   = 50_000;
  localparam int DEF_LONG_MS    = 1000;
  localparam int DEF_REPEAT_MS  = 200;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: small show-ahead event FIFO. The head entry is always visible
// on head; push and pop may happen in the same cycle, even when full.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic     sys_clk,
  input  logic     sys_rstn,
  input  logic     push,
  input  key_evt_t push_data,
  input  logic     pop,
  output key_evt_t head,
  output logic     empty,
  output logic     full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  key_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: turns four debounced active-low key levels into timed
// PRESS / LONG / REPEAT / RELEASE events, serialised through a fixed-priority
// arbiter into a show-ahead FIFO with a valid/ready output.
// Build option: define KEY_EVT_REPEAT_EN to enable auto-repeat after LONG.
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int LONG_MS    = DEF_LONG_MS,
  parameter int REPEAT_MS  = DEF_REPEAT_MS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       sys_clk,
  input  logic       sys_rstn,
  input  logic [3:0] key_level,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_key,
  output logic [1:0] evt_type,
  output logic       evt_overflow,
  input  logic       clr_overflow
);

  localparam int          TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] LONG_16 = 16'(LONG_MS);

  logic [TICK_W-1:0] tick_cnt_reg;
  logic              tick;
  logic [3:0]        level_reg;
  logic [3:0]        prev_level_reg;
  logic [3:0]        fall;
  logic [3:0]        rise;
  logic [3:0]        raise;
  logic [3:0][1:0]   raise_type;
  logic [3:0]        pend_valid_reg;
  logic [3:0][1:0]   pend_type_reg;
  logic [3:0]        grant;
  logic [1:0]        grant_idx;
  logic [3:0]        drop;
  logic              ovf_reg;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;
  logic              push_ok;
  key_evt_t          push_evt;
  key_evt_t          head_evt;

  assign tick = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

  // Free-running millisecond prescaler
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) tick_cnt_reg <= '0;
    else if (tick) tick_cnt_reg <= '0;
    else           tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  // Sample the levels, keep the previous sample for edge detection; both reset
  // to released so a key held through reset yields a fresh PRESS
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      level_reg      <= 4'hF;
      prev_level_reg <= 4'hF;
    end else begin
      level_reg      <= key_level;
      prev_level_reg <= level_reg;
    end
  end

  assign fall = prev_level_reg & ~level_reg;
  assign rise = ~prev_level_reg & level_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      key_state_t  state_reg;
      key_state_t  state_next;
      logic [15:0] ms_cnt_reg;
      logic [15:0] ms_cnt_next;
      logic [15:0] ms_inc;
      logic        ev_raise;
      evt_type_t   ev_type;

      assign ms_inc = (ms_cnt_reg == 16'hFFFF) ? ms_cnt_reg : ms_cnt_reg + 16'd1;

      // Key FSM state and saturating ms counter
      always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
          state_reg  <= ST_IDLE;
          ms_cnt_reg <= '0;
        end else begin
          state_reg  <= state_next;
          ms_cnt_reg <= ms_cnt_next;
        end
      end

      // Next state and event generation; release beats a same-cycle timer event
      always_comb begin
        state_next  = state_reg;
        ms_cnt_next = ms_cnt_reg;
        ev_raise    = 1'b0;
        ev_type     = EVT_RELEASE;
        case (state_reg)
          ST_IDLE: begin
            if (fall[gi]) begin
              ev_raise    = 1'b1;
              ev_type     = EVT_PRESS;
              ms_cnt_next = '0;
              state_next  = ST_HELD;
            end
          end
          ST_HELD: begin
            if (rise[gi]) begin
              ev_raise   = 1'b1;
              ev_type    = EVT_RELEASE;
              state_next = ST_IDLE;
            end else if (tick) begin
              ms_cnt_next = ms_inc;
              if (ms_inc == LONG_16) begin
                ev_raise = 1'b1;
                ev_type  = EVT_LONG;
`ifdef KEY_EVT_REPEAT_EN
                ms_cnt_next = '0;
                state_next  = ST_REPEAT;
`else
                // Park the counter at all-ones so LONG cannot match again
                ms_cnt_next = 16'hFFFF;
`endif
              end
            end
          end
          ST_REPEAT: begin
`ifdef KEY_EVT_REPEAT_EN
            if (rise[gi]) begin
              ev_raise   = 1'b1;
              ev_type    = EVT_RELEASE;
              state_next = ST_IDLE;
            end else if (tick) begin
              ms_cnt_next = ms_inc;
              if (ms_inc == 16'(REPEAT_MS)) begin
                ev_raise    = 1'b1;
                ev_type     = EVT_REPEAT;
                ms_cnt_next = '0;
              end
            end
`else
            state_next = ST_IDLE;
`endif
          end
          default: state_next = ST_IDLE;
        endcase
      end

      assign raise[gi]      = ev_raise;
      assign raise_type[gi] = ev_type;
    end
  endgenerate

`ifndef KEY_EVT_REPEAT_EN
  logic [15:0] unused_repeat_ms;
  assign unused_repeat_ms = 16'(REPEAT_MS);
`endif

  assign fifo_pop = !fifo_empty && evt_ready;
  assign push_ok  = !fifo_full || fifo_pop;

  // Fixed-priority arbiter: lowest-numbered pending key wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (push_ok) begin
      for (int i = 3; i >= 0; i--) begin
        if (pend_valid_reg[i]) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = 2'(i);
        end
      end
    end
  end

  // A slot leaving through the arbiter this cycle counts as free again
  assign drop = raise & pend_valid_reg & ~grant;

  // Pending slots: accept new events into free slots, clear granted ones
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      pend_valid_reg <= '0;
      pend_type_reg  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (raise[i] && !drop[i]) begin
          pend_valid_reg[i] <= 1'b1;
          pend_type_reg[i]  <= raise_type[i];
        end else if (grant[i]) begin
          pend_valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow flag; a new drop wins over a clear request
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn)         ovf_reg <= 1'b0;
    else if (|drop)        ovf_reg <= 1'b1;
    else if (clr_overflow) ovf_reg <= 1'b0;
  end

  assign push_evt.key   = grant_idx;
  assign push_evt.etype = pend_type_reg[grant_idx];

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rstn  (sys_rstn),
    .push      (|grant),
    .push_data (push_evt),
    .pop       (fifo_pop),
    .head      (head_evt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Outputs read zero while the FIFO is empty
  assign evt_valid    = !fifo_empty;
  assign evt_key      = fifo_empty ? 2'b00 : head_evt.key;
  assign evt_type     = fifo_empty ? 2'b00 : head_evt.etype;
  assign evt_overflow = ovf_reg;

endmodule
